// File: rtl/spi_recv_if.sv
// spi_recv_if: serial frame inputs and parallel word outputs of the SPI receiver
interface spi_recv_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  Enable;
  logic                  SerialIN;
  logic [DATA_WIDTH-1:0] DataIN;
  logic                  DataCLK;
  modport master (output Enable, output SerialIN, input DataIN, input DataCLK);
  modport slave  (input Enable, input SerialIN, output DataIN, output DataCLK);
endinterface

// File: rtl/spi_recv.sv
// spi_recv: skips lead-in bits, shifts in an MSB-first word and strobes it out once per frame
module spi_recv #(
  parameter int DATA_WIDTH = 10,
  parameter int SKIP_BITS  = 3
) (
  input logic       CLK,
  input logic       RST_N,
  spi_recv_if.slave bus
);
  localparam int CW = $clog2(SKIP_BITS + DATA_WIDTH + 1);
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  done;
  logic                  payload;
  logic                  last;
  logic [DATA_WIDTH-1:0] next_word;
  // decode where the current edge falls in the frame and the word it would complete
  always_comb begin
    payload   = cnt >= CW'(SKIP_BITS);
    last      = cnt == CW'(SKIP_BITS + DATA_WIDTH - 1);
    next_word = {shreg[DATA_WIDTH-2:0], bus.SerialIN};
  end
  // count frame edges, shift payload bits, publish the word with a one-cycle strobe
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt         <= '0;
      shreg       <= '0;
      done        <= 1'b0;
      bus.DataIN  <= '0;
      bus.DataCLK <= 1'b0;
    end else if (!bus.Enable) begin
      cnt         <= '0;
      done        <= 1'b0;
      bus.DataCLK <= 1'b0;
    end else begin
      bus.DataCLK <= 1'b0;
      if (!done) begin
        cnt <= cnt + 1'b1;
        if (payload) shreg <= next_word;
        if (last) begin
          bus.DataIN  <= next_word;
          bus.DataCLK <= 1'b1;
          done        <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_recv.sv
// tb_spi_recv: frame-level reference model plus directed tables and random frames for spi_recv
module tb_spi_recv;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  spi_recv_if #(.DATA_WIDTH(10)) bus ();
  spi_recv #(.DATA_WIDTH(10), .SKIP_BITS(3)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [9:0] word;
    logic [2:0] lead;
    logic [9:0] exp;
  } vec_t;
  vec_t vecs[5];
  // reference model: edges 1..13 of a frame are recorded, word built from edges 4..13
  int         k;
  logic [12:0] fb;
  logic [9:0] m_data;
  logic       m_stb;
  function automatic logic [9:0] word_of(input logic [12:0] b, input logic lastbit);
    logic [9:0] w = '0;
    for (int i = 0; i < 9; i++) w = w | (10'(b[3+i]) << (9 - i));
    return w | 10'(lastbit);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; fb <= '0; m_data <= '0; m_stb <= 1'b0;
    end else if (!bus.Enable) begin
      k <= 0; m_stb <= 1'b0;
    end else begin
      m_stb <= 1'b0;
      if (k < 13) begin
        fb[k] <= bus.SerialIN;
        k <= k + 1;
        if (k == 12) begin
          m_data <= word_of(fb, bus.SerialIN);
          m_stb  <= 1'b1;
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // every cycle the DUT must agree with the model; strobes are counted for frame checks
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_data", 32'(bus.DataIN), 32'(m_data));
      chk("model_strobe", 32'(bus.DataCLK), 32'(m_stb));
      if (bus.DataCLK) pulses++;
    end
  end
  task automatic drive(input logic en, input logic si);
    @(negedge clk);
    bus.Enable   = en;
    bus.SerialIN = si;
  endtask
  task automatic send(input logic [9:0] w, input logic [2:0] lead);
    for (int i = 2; i >= 0; i--) drive(1'b1, lead[i]);
    for (int i = 9; i >= 0; i--) drive(1'b1, w[i]);
  endtask
  initial begin
    int p0;
    logic [9:0] w;
    vecs[0] = '{10'h2A5, 3'b000, 10'h2A5};
    vecs[1] = '{10'h3FF, 3'b111, 10'h3FF};
    vecs[2] = '{10'h000, 3'b111, 10'h000};
    vecs[3] = '{10'h0F0, 3'b101, 10'h0F0};
    vecs[4] = '{10'h1C3, 3'b010, 10'h1C3};
    rst_n = 1'b0;
    bus.Enable = 1'b0;
    bus.SerialIN = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(bus.DataIN), 32'h0);
    chk("reset_strobe", 32'(bus.DataCLK), 32'h0);
    rst_n = 1'b1;
    send(10'h2A5, 3'b000);
    drive(1'b0, 1'b0);
    chk("first_strobe_hi", 32'(bus.DataCLK), 32'h1);
    chk("first_data", 32'(bus.DataIN), 32'h2A5);
    drive(1'b0, 1'b0);
    chk("first_strobe_lo", 32'(bus.DataCLK), 32'h0);
    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      send(vecs[i].word, vecs[i].lead);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      chk("table_data", 32'(bus.DataIN), 32'(vecs[i].exp));
      chk("table_pulses", 32'(pulses - p0), 32'h1);
    end
    p0 = pulses;
    for (int i = 0; i < 1024; i++) begin
      send(10'(i), 3'($urandom));
      drive(1'b0, 1'b0);
      chk("sweep_data", 32'(bus.DataIN), 32'(i));
    end
    drive(1'b0, 1'b0);
    chk("sweep_pulses", 32'(pulses - p0), 32'd1024);
    p0 = pulses;
    send(10'h19A, 3'b000);
    for (int i = 0; i < 7; i++) drive(1'b1, i[0]);
    chk("overrun_data", 32'(bus.DataIN), 32'h19A);
    chk("overrun_strobe", 32'(bus.DataCLK), 32'h0);
    drive(1'b0, 1'b0);
    chk("overrun_pulses", 32'(pulses - p0), 32'h1);
    send(10'h0F0, 3'b000);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    p0 = pulses;
    w = 10'h155;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    for (int i = 9; i >= 5; i--) drive(1'b1, w[i]);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    chk("abort_data", 32'(bus.DataIN), 32'h0F0);
    chk("abort_pulses", 32'(pulses - p0), 32'h0);
    send(10'h155, 3'b000);
    drive(1'b0, 1'b0);
    chk("after_abort_data", 32'(bus.DataIN), 32'h155);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    bus.Enable = 1'b0;
    #1 chk("async_rst_data", 32'(bus.DataIN), 32'h0);
    chk("async_rst_strobe", 32'(bus.DataCLK), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(10'h1C3, 3'b101);
    drive(1'b0, 1'b0);
    chk("post_rst_data", 32'(bus.DataIN), 32'h1C3);
    send(10'h2B4, 3'b000);
    @(posedge clk);
    #2 chk("pre_rst_strobe", 32'(bus.DataCLK), 32'h1);
    rst_n = 1'b0;
    bus.Enable = 1'b0;
    #1 chk("rst_kills_strobe", 32'(bus.DataCLK), 32'h0);
    chk("rst_kills_data", 32'(bus.DataIN), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      w = 10'($urandom);
      send(w, 3'($urandom));
      drive(1'b0, 1'b0);
      chk("rand_frame", 32'(bus.DataIN), 32'(w));
    end
    for (int i = 0; i < 600; i++) drive($urandom_range(0, 15) != 0, 1'($urandom));
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_recv.md
Name: spi_recv

Overview:
- Serial-to-parallel receiver for a 10-bit SPI-style converter stream; MSB first, preceded by a fixed number of ignored lead-in bits (two sample/acquisition clocks plus one null bit).
- Sits between an external serial data line and downstream logic.
- Presents the completed word on a parallel bus together with a one-clock strobe.
- All logic runs in the single CLK domain; Enable acts as the active-high frame select.

Parameters:
- DATA_WIDTH, 10, number of payload bits per frame (width of DataIN).
- SKIP_BITS, 3, number of leading bits in each frame that are discarded before the payload MSB.

Ports:
- CLK  input  1  system/serial clock; all sampling on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- Enable  input  1  frame active when high; low aborts/ends frame.
- SerialIN  input  1  serial data, sampled on CLK rising edge, MSB first.
- DataIN  output  DATA_WIDTH  last completely received word.
- DataCLK  output  1  one-CLK-cycle strobe, high when DataIN has just been updated.

Behaviour:
- Reset (RST_N low, asynchronous):
  - DataIN = 0, DataCLK = 0, bit counter = 0, shift register = 0, done flag = 0.
  - Release is synchronous to the next CLK edge.
- Idle: while Enable = 0 at a rising edge:
  - bit counter ← 0, done ← 0, DataCLK ← 0.
  - DataIN holds its value.
- Frame counting: each rising edge with Enable = 1 and done = 0 samples SerialIN and increments the counter.
  - Counter values 0 … SKIP_BITS−1 (edges 1–3 of the frame): bits discarded.
  - Counter values SKIP_BITS … SKIP_BITS+DATA_WIDTH−1 (edges 4–13): SerialIN shifted in MSB first, i.e. D9 on edge 4 through D0 on edge 13.
- Completion (edge sampling the last payload bit, edge 13):
  - DataIN ← full word, with SerialIN as bit 0.
  - DataCLK ← 1 and done ← 1.
  - DataIN and DataCLK change on the same edge, so DataIN is valid whenever DataCLK = 1.
- DataCLK: high exactly one CLK period, cleared on the following edge regardless of Enable.
- After completion: further edges with Enable = 1 are ignored.
  - No shifting, no counter wrap, no second strobe.
  - A new frame needs Enable to be sampled low at least once.
- Abort: if Enable falls before the last payload bit, the partial word is discarded; DataIN keeps its old value and no strobe is issued.
- Enable rising on the edge right after a completed frame's deassertion starts a fresh frame at counter 0.
- Counter width: ≥ clog2(SKIP_BITS+DATA_WIDTH+1); it must never wrap within a frame.
- No other latency: the strobe is on the same edge as the last bit sample.

Test Plan:
- Reset, then frame with Enable = 1 and SerialIN = 0,0,0 then bits of 0x2A5 MSB first over 13 edges → DataIN = 0x2A5 on edge 13, DataCLK high one cycle, then low.
- Sweep all 1024 words, each as a 13-edge frame followed by Enable low for ≥1 edge → DataIN matches every word, exactly one DataCLK pulse per frame.
- Word 0x3FF then word 0x000 → DataIN 0x3FF then 0x000; lead-in bits forced to 1 for both frames, with no effect on the result.
- Enable held high for 20 edges with SerialIN toggling after edge 13 → single strobe, DataIN unchanged after edge 13.
- Enable dropped after edge 8 of a frame carrying 0x155, after a prior good frame of 0x0F0 → DataIN stays 0x0F0, no strobe; the next full frame of 0x155 gives 0x155.
- RST_N pulsed low mid-frame (after edge 6) → DataIN = 0 and DataCLK = 0 immediately (asynchronous); the following full frame of 0x1C3 is received correctly.
